// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter owning the register file's write port and read port 1.
// Define REGFILE_CLEAR_EN to add the post-reset / soft_clear zeroing sequence.
module regfile_port_arbiter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned REGISTER_BITS = 4,
  parameter int unsigned NUM_REQ       = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             soft_clear,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*REGISTER_BITS-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [WIDTH-1:0]                 rsp_data,
  output logic                             busy,
  output logic                             rf_shouldWrite,
  output logic [REGISTER_BITS-1:0]         rf_writeAddress,
  output logic [WIDTH-1:0]                 rf_writeData,
  output logic [REGISTER_BITS-1:0]         rf_readAddress,
  input  logic [WIDTH-1:0]                 rf_readData
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    RUN,
    CLEAR
  } state_t;

`ifdef REGFILE_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = RUN;
  logic unused_soft_clear;
  assign unused_soft_clear = soft_clear;
`endif

  state_t                   state, state_next;
  logic [IDXW-1:0]          rr_last;
  logic [IDXW-1:0]          win;
  logic                     win_found;
  logic                     win_write;
  logic [REGISTER_BITS-1:0] win_addr;
  logic [WIDTH-1:0]         win_wdata;
  logic [REGISTER_BITS-1:0] clear_addr;
  logic                     transfer;

  // Search starts just after the last winner and wraps, so the index sum never exceeds 2*NUM_REQ.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win       = rr_last;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(rr_last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[IDXW'(cand)]) begin
        win_found = 1'b1;
        win       = IDXW'(cand);
      end
    end
    win_write = req_write[win];
    win_addr  = req_addr[32'(win)*REGISTER_BITS +: REGISTER_BITS];
    win_wdata = req_wdata[32'(win)*WIDTH +: WIDTH];
  end

  assign transfer = (state == RUN) && win_found;
  assign busy     = (state == CLEAR);

  always_comb begin
    state_next      = state;
    req_ready       = '0;
    rf_shouldWrite  = 1'b0;
    rf_writeAddress = '0;
    rf_writeData    = '0;
    rf_readAddress  = '0;
    case (state)
      RUN: begin
        if (win_found) begin
          req_ready[win] = 1'b1;
          if (win_write) begin
            rf_shouldWrite  = 1'b1;
            rf_writeAddress = win_addr;
            rf_writeData    = win_wdata;
          end else begin
            rf_readAddress = win_addr;
          end
        end
`ifdef REGFILE_CLEAR_EN
        if (soft_clear) state_next = CLEAR;
`endif
      end
      CLEAR: begin
        rf_shouldWrite  = 1'b1;
        rf_writeAddress = clear_addr;
        if (clear_addr == '1) state_next = RUN;
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      rr_last    <= IDXW'(NUM_REQ - 1);
      clear_addr <= REGISTER_BITS'(1);
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= '0;
      if (transfer) begin
        rr_last <= win;
        if (!win_write) begin
          rsp_valid[win] <= 1'b1;
          rsp_data       <= rf_readData;
        end
      end
      if (state == CLEAR) begin
        clear_addr <= (clear_addr == '1) ? REGISTER_BITS'(1) : clear_addr + REGISTER_BITS'(1);
      end
    end
  end

endmodule
